// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store per handshake, forwards it to a
// request/response backing bus and returns aligned read data, with a stuck-bus timeout.
module dmem_responder #(
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [7:0]        req_wmask,
  input  logic [63:0]       req_wdata,
  output logic              rsp_valid,
  output logic [63:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [2:0]        cache_state,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wen,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [63:0]       mem_req_wdata,
  output logic [7:0]        mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [63:0]       mem_rsp_rdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_RESP = 3'd3
  } state_t;

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [63:0]      repl_data;
  logic             timed_out;
  logic             unused_addr_bits;

  // Backing bus is doubleword-granular; the byte offset is carried by the mask.
  assign unused_addr_bits = ^req_addr[2:0];

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    repl_data = req_wdata;
    case (req_size)
      2'b00:   repl_data = {8{req_wdata[7:0]}};
      2'b01:   repl_data = {4{req_wdata[15:0]}};
      2'b10:   repl_data = {2{req_wdata[31:0]}};
      default: repl_data = req_wdata;
    endcase
  end

  // A response arriving in the same cycle as the limit takes priority below.
  assign timed_out   = (TIMEOUT != 0) && (count == CNT_W'(TIMEOUT));
  assign cache_state = state;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: every register, data paths included, is cleared by reset because the
  // reset values are architecturally visible on the ports.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      count         <= '0;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_wen   <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            mem_req_wen   <= req_wen;
            mem_req_addr  <= {req_addr[ADDR_W-1:3], 3'b000};
            mem_req_wdata <= repl_data;
            mem_req_wmask <= req_wen ? req_wmask : 8'h00;
            mem_req_valid <= 1'b1;
            req_ready     <= 1'b0;
            state         <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            count         <= '0;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            rsp_rdata <= mem_req_wen ? 64'h0 : mem_rsp_rdata;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else if (timed_out) begin
            rsp_rdata <= 64'h0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        S_RESP: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the load/store pipeline stage: accepts one load or store per handshake and returns 64-bit doubly aligned read data plus a 3-bit state word.
- The pipeline supplies the byte mask. This block replicates store data by size and drives a simple request/response backing-memory bus.
- Per-request timeout counter flags a stuck backing bus.

Parameters:
- ADDR_W, 64, request/backing address width
- TIMEOUT, 255, cycles in WAIT before error; 0 disables timeout

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- req_valid  in  1  pipeline request valid
- req_ready  out  1  block can accept a request
- req_wen  in  1  1=store, 0=load
- req_addr  in  ADDR_W  byte address
- req_size  in  2  00=byte 01=half 10=word 11=double
- req_wmask  in  8  byte-lane write mask, already computed by pipeline
- req_wdata  in  64  store data, low bytes significant
- rsp_valid  out  1  one-cycle pulse: load data / store completion
- rsp_rdata  out  64  doubly aligned read data (stores: 0)
- rsp_err  out  1  qualifies rsp_valid: timeout occurred
- cache_state  out  3  current FSM state encoding
- mem_req_valid  out  1  backing request valid
- mem_req_ready  in  1  backing accepts request
- mem_req_wen  out  1  backing write
- mem_req_addr  out  ADDR_W  req_addr with [2:0] forced 0
- mem_req_wdata  out  64  replicated store data
- mem_req_wmask  out  8  latched req_wmask (0 for loads)
- mem_rsp_valid  in  1  backing response valid
- mem_rsp_rdata  in  64  backing read data

Behaviour:
- Reset (rst=0, async): state IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_req_valid=0, mem_req_wen=0, mem_req_addr=0, mem_req_wdata=0, mem_req_wmask=0, timeout counter=0.
- State encoding on cache_state: IDLE=0, REQ=1, WAIT=2, RESP=3. Codes 4-7 are unused and never driven.
- IDLE:
  - req_ready=1.
  - On req_valid: latch wen, aligned address, wmask and replicated data, then go to REQ.
  - Replication: byte={8{d[7:0]}}, half={4{d[15:0]}}, word={2{d[31:0]}}, double=d.
- REQ:
  - mem_req_valid=1 with the latched fields held stable.
  - On mem_req_ready go to WAIT and clear the counter.
  - Outputs must not change while waiting for mem_req_ready.
- WAIT:
  - Counter increments each cycle.
  - On mem_rsp_valid: capture mem_rsp_rdata (loads) or 0 (stores); go to RESP with err=0.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT without mem_rsp_valid: go to RESP with err=1, rdata=0.
  - mem_rsp_valid in the same cycle the counter hits TIMEOUT: the response wins (err=0).
- RESP:
  - rsp_valid=1 for exactly one cycle; rsp_rdata and rsp_err are valid that cycle.
  - Return to IDLE next cycle.
  - rsp_rdata holds its value until the next capture.
- req_ready is 0 in REQ, WAIT and RESP. A request presented then is not accepted and must be held by the pipeline.
- mem_rsp_valid outside WAIT is ignored.
- Latency from request accept to rsp_valid: minimum 3 cycles (accept, REQ with immediate ready, WAIT with immediate response, RESP pulse). Exact latency is 3 + request stall + response stall.
- The block does not modify req_wmask; a mask inconsistent with size is passed through unchanged.
- rst asserted mid-transaction: immediate return to reset values, and the outstanding transaction is dropped.

Test Plan:
- Load double: addr=0x80000008, backing returns 0x1122334455667788 with zero stall → mem_req_addr=0x80000008, rsp_valid at accept+3, rsp_rdata=0x1122334455667788, rsp_err=0.
- Store byte: addr=0x80000005, wdata=0xAB, wmask=0x20 → mem_req_wdata=0xABABABABABABABAB, wmask=0x20, addr=0x80000000, rsp_rdata=0.
- Backing stall: mem_req_ready low 4 cycles, then response after 2 more → mem_req_* stable throughout, rsp_valid at accept+9, single pulse.
- Timeout: TIMEOUT=8, mem_rsp_valid never asserted → rsp_valid with rsp_err=1, rdata=0, cache_state back to 0 next cycle.
- Simultaneous response and timeout at count=TIMEOUT → rsp_err=0, data captured.
- Reset pulse while in WAIT → all outputs return to reset values asynchronously, req_ready=1 after release, a later mem_rsp_valid is ignored.
